load_store_unit: RTL

- Memory-side block of the 3-stage core: issues load/store requests to data memory over a valid/ready bus.
- Generates store byte enables and aligned write data.
- Returns sign- or zero-extended load data as data_memory_output for the writeback select stage.
- Stalls the pipeline while a bus transaction is in flight.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/load_formatter.sv | 26 ++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and the load data formatter.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // RISC-V func3 width/sign codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // True when func3 is a defined code for the direction and the address is naturally aligned.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            case (f3)
                SB:      ok = 1'b1;
                SH:      ok = ~lane[0];
                SW:      ok = (lane == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                LB, LBU: ok = 1'b1;
                LH, LHU: ok = ~lane[0];
                LW:      ok = (lane == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Lane select plus sign/zero extension of a read word; shared with the writeback path.
module load_formatter
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (func3)
            LB:      result = {{24{byte_sel[7]}}, byte_sel};
            LH:      result = {{16{half_sel[15]}}, half_sel};
            LBU:     result = {24'h000000, byte_sel};
            LHU:     result = {16'h0000, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-side load/store unit: one outstanding bus transaction, stalls the core while busy.
// Optional response watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [31:0]       rs2_data,
    output logic [31:0]       data_memory_output,
    output logic              load_done,
    output logic              stall,
    output logic              access_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rdata
);

    lsu_state_t  state;
    logic [2:0]  func3_q;
    logic [1:0]  lane_q;
    logic [31:0] fmt_rdata;
    logic        req;
    logic        legal;
    logic        wd_expired;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        case (f3)
            SB:      be = BE_BYTE << lane;
            SH:      be = BE_HALF << {lane[1], 1'b0};
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            SB:      w = {4{d[7:0]}};
            SH:      w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // A simultaneous rd_en/wr_en is a store, so legality is judged by wr_en.
    assign req   = rd_en | wr_en;
    assign legal = access_legal(wr_en, func3, alu_out[1:0]);
    assign stall = (state == REQ) || (state == WAIT) || ((state == IDLE) && req && legal);

    load_formatter u_fmt (
        .func3   (func3_q),
        .addr_lo (lane_q),
        .rdata   (bus_rdata),
        .result  (fmt_rdata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;

    // Restarts on entry to REQ (from IDLE) and to WAIT (at the request handshake).
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state == DONE || (state == REQ && bus_req_ready))
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            func3_q            <= '0;
            lane_q             <= '0;
            bus_req_valid      <= 1'b0;
            bus_we             <= 1'b0;
            bus_addr           <= '0;
            bus_wdata          <= '0;
            bus_be             <= '0;
            data_memory_output <= '0;
            load_done          <= 1'b0;
            access_err         <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            access_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (legal) begin
                            func3_q       <= func3;
                            lane_q        <= alu_out[1:0];
                            bus_we        <= wr_en;
                            bus_addr      <= {alu_out[ADDR_W-1:2], 2'b00};
                            bus_be        <= wr_en ? store_be(func3, alu_out[1:0]) : BE_WORD;
                            bus_wdata     <= wr_en ? store_wdata(func3, rs2_data) : 32'h0;
                            bus_req_valid <= 1'b1;
                            state         <= REQ;
                        end else begin
                            access_err <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        state         <= bus_we ? DONE : WAIT;
                    end else if (wd_expired) begin
                        bus_req_valid <= 1'b0;
                        access_err    <= 1'b1;
                        state         <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus_rsp_valid) begin
                        data_memory_output <= fmt_rdata;
                        load_done          <= 1'b1;
                        state              <= DONE;
                    end else if (wd_expired) begin
                        access_err <= 1'b1;
                        state      <= IDLE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
